elevator_scheduler: RTL
=======================

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, cycles to wait for car to leave idle after an issue before re-queueing the target.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: hall_req  input  8  per-floor hall-call pulses; bit n = floor n.
REQ-005 SHALL have port: cab_req  input  8  per-floor cabin-button pulses; bit n = floor n.
REQ-006 SHALL have port: emergency_in  input  1  level; car halted while high.
REQ-007 SHALL have port: car_idle  input  1  high when the car is in its IDLE state.
REQ-008 SHALL have port: car_floor  input  3  current car floor.
REQ-009 SHALL have port: req_floor  output  3  target floor presented to the car.
REQ-010 SHALL have port: direction  output  1  1 = up, 0 = down, relative to car_floor at issue.
REQ-011 SHALL have port: valid_out  output  1  one-cycle issue strobe, qualifies req_floor/direction.
REQ-012 SHALL have port: emergency  output  1  registered copy of emergency_in, driven to car.
REQ-013 SHALL have port: pending  output  8  outstanding request bitmap.

Function
REQ-014 SHALL OR hall_req|cab_req into pending each cycle; a set and a clear of the same bit in one cycle SHALL leave the bit set.
REQ-015 SHALL implement states S_IDLE, S_SELECT, S_ISSUE, S_WAIT_BUSY, S_WAIT_IDLE, S_HALT.
REQ-016 S_IDLE -> S_SELECT when pending != 0 and car_idle = 1.
REQ-017 S_SELECT SHALL clear pending[car_floor] if set, then pick target via LOOK: scan_dir up -> nearest pending floor above car_floor, else nearest below with scan_dir flipped to down; mirror for down; no other pending -> S_IDLE.
REQ-018 S_SELECT -> S_ISSUE one cycle after entry with target registered; selection latency pending-to-valid_out SHALL be 2 cycles from S_IDLE exit.
REQ-019 S_ISSUE SHALL assert valid_out for exactly one cycle, drive req_floor = target, direction = (target > car_floor), clear pending[target], -> S_WAIT_BUSY.
REQ-020 S_WAIT_BUSY -> S_WAIT_IDLE when car_idle = 0; after TIMEOUT cycles with car_idle still 1 SHALL re-set pending[target] and -> S_SELECT.
REQ-021 S_WAIT_IDLE -> S_SELECT when car_idle = 1.
REQ-022 emergency_in = 1 SHALL force S_HALT from any state next cycle; valid_out = 0 in S_HALT; S_HALT -> S_IDLE when emergency_in = 0; a target issued but not reached SHALL be re-set in pending on S_HALT entry.
REQ-023 req_floor and direction SHALL hold their last issued values between strobes.
REQ-024 valid_out SHALL never assert on two consecutive cycles.

Reset
REQ-025 On reset: state S_IDLE, pending 0, req_floor 0, direction 0, valid_out 0, emergency 0, scan_dir up, timeout counter 0.
REQ-026 Reset mid-operation SHALL discard all pending requests and any in-flight issue immediately (asynchronous).

Configuration
REQ-027 Macro SCHED_FLUSH_ON_EMERGENCY_EN defined: pending SHALL be cleared to 0 on S_HALT entry and REQ-022 re-queue suppressed; undefined: pending retained through S_HALT.

Verification
REQ-028 Reset, car_floor 0, car_idle 1, cab_req[3] pulse -> valid_out one cycle, req_floor 3, direction 1, pending 0x00.
REQ-029 car_floor 2, scan up, pending {5,1,4} -> issues 4, then 5, then 1 (direction 0), one strobe per car_idle rise.
REQ-030 Request at car_floor 2 while car_floor = 2 -> bit cleared in S_SELECT, no valid_out.
REQ-031 Issue floor 6, car_idle held 1 for TIMEOUT (16) cycles -> pending[6] re-set, re-issued floor 6.
REQ-032 emergency_in high during S_WAIT_IDLE with pending {7} -> emergency 1, no valid_out; release -> floor 7 issued (macro undefined) or pending 0 and no issue (macro defined).

Source files
------------

// File: rtl/elevator_scheduler.sv
// elevator_scheduler
//   Collects hall and cabin calls into a pending bitmap and hands one target
//   floor at a time to the car controller using a LOOK policy (keep going in
//   the current scan direction while requests remain that way, then reverse).
//
//   Ports
//     clk           single clock, all state on the rising edge
//     reset         asynchronous, active-high
//     hall_req[7:0] hall-call pulses, bit n = floor n
//     cab_req[7:0]  cabin-button pulses, bit n = floor n
//     emergency_in  level; scheduler halts while high
//     car_idle      car controller is in its IDLE state
//     car_floor     current car floor
//     req_floor     target floor, held between strobes
//     direction     1 = target above car_floor at issue time
//     valid_out     one-cycle issue strobe qualifying req_floor/direction
//     emergency     registered copy of emergency_in
//     pending[7:0]  outstanding request bitmap
//
//   Build option
//     SCHED_FLUSH_ON_EMERGENCY_EN : when defined, the pending bitmap is
//     cleared on entry to halt and the in-flight target is not re-queued.
//     When undefined, pending survives the halt and the in-flight target is
//     re-queued.
module elevator_scheduler #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] hall_req,
    input  logic [7:0] cab_req,
    input  logic       emergency_in,
    input  logic       car_idle,
    input  logic [2:0] car_floor,
    output logic [2:0] req_floor,
    output logic       direction,
    output logic       valid_out,
    output logic       emergency,
    output logic [7:0] pending
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_IDLE,
        S_HALT
    } state_t;

    state_t        state_reg;
    logic [7:0]    pending_reg, pending_next;
    logic [2:0]    target_reg;
    logic          scan_up_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    req_floor_reg;
    logic          direction_reg;
    logic          valid_reg;
    logic          emergency_reg;

    // ------------------------------------------------------------------
    // LOOK candidate selection
    // ------------------------------------------------------------------
    logic [7:0] above_mask, below_mask;
    logic [7:0] cand, above, below;
    logic [2:0] up_idx, dn_idx;
    logic       sel_valid, sel_scan_up;
    logic [2:0] sel_target;

    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
        assign above_mask[gi] = (3'(gi) > car_floor);
        assign below_mask[gi] = (3'(gi) < car_floor);
    end

    // The car's own floor is being cleared this cycle, so it never competes.
    assign cand  = pending_reg & ~(8'b1 << car_floor);
    assign above = cand & above_mask;
    assign below = cand & below_mask;

    always_comb begin
        // nearest above = lowest set bit, nearest below = highest set bit
        up_idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (above[i]) up_idx = 3'(i);
        dn_idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (below[i]) dn_idx = 3'(i);
    end

    always_comb begin
        sel_valid   = 1'b0;
        sel_target  = 3'd0;
        sel_scan_up = scan_up_reg;
        if (scan_up_reg) begin
            if (|above) begin
                sel_valid = 1'b1; sel_target = up_idx; sel_scan_up = 1'b1;
            end else if (|below) begin
                sel_valid = 1'b1; sel_target = dn_idx; sel_scan_up = 1'b0;
            end
        end else begin
            if (|below) begin
                sel_valid = 1'b1; sel_target = dn_idx; sel_scan_up = 1'b0;
            end else if (|above) begin
                sel_valid = 1'b1; sel_target = up_idx; sel_scan_up = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending bitmap update: new calls and re-queues always win over clears
    // ------------------------------------------------------------------
    logic [7:0] clr_mask, set_mask;
    logic       timeout_hit, in_flight;

    assign timeout_hit = (state_reg == S_WAIT_BUSY) && car_idle &&
                         (cnt_reg == CW'(TIMEOUT - 1));
    assign in_flight   = (state_reg == S_ISSUE) || (state_reg == S_WAIT_BUSY) ||
                         (state_reg == S_WAIT_IDLE);

    always_comb begin
        clr_mask = 8'h00;
        set_mask = 8'h00;
        case (state_reg)
            S_SELECT: clr_mask = 8'b1 << car_floor;
            S_ISSUE:  clr_mask = 8'b1 << target_reg;
            default:  ;
        endcase
        if (timeout_hit)
            set_mask = 8'b1 << target_reg;
        if (emergency_in && state_reg != S_HALT) begin
`ifdef SCHED_FLUSH_ON_EMERGENCY_EN
            clr_mask = 8'hFF;
            set_mask = 8'h00;
`else
            if (in_flight)
                set_mask = set_mask | (8'b1 << target_reg);
`endif
        end
        pending_next = (pending_reg & ~clr_mask) | set_mask | hall_req | cab_req;
    end

    // ------------------------------------------------------------------
    // Scheduler FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            pending_reg   <= 8'h00;
            target_reg    <= 3'd0;
            scan_up_reg   <= 1'b1;
            cnt_reg       <= '0;
            req_floor_reg <= 3'd0;
            direction_reg <= 1'b0;
            valid_reg     <= 1'b0;
            emergency_reg <= 1'b0;
        end else begin
            pending_reg   <= pending_next;
            emergency_reg <= emergency_in;
            valid_reg     <= 1'b0;
            if (emergency_in) begin
                state_reg <= S_HALT;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    S_IDLE:
                        if (|pending_reg && car_idle) state_reg <= S_SELECT;
                    S_SELECT:
                        if (sel_valid) begin
                            target_reg    <= sel_target;
                            req_floor_reg <= sel_target;
                            direction_reg <= (sel_target > car_floor);
                            scan_up_reg   <= sel_scan_up;
                            valid_reg     <= 1'b1;
                            state_reg     <= S_ISSUE;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    S_ISSUE: begin
                        cnt_reg   <= '0;
                        state_reg <= S_WAIT_BUSY;
                    end
                    S_WAIT_BUSY:
                        if (!car_idle) begin
                            cnt_reg   <= '0;
                            state_reg <= S_WAIT_IDLE;
                        end else if (timeout_hit) begin
                            // car never left idle; target re-queued via set_mask
                            cnt_reg   <= '0;
                            state_reg <= S_SELECT;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    S_WAIT_IDLE:
                        if (car_idle) state_reg <= S_SELECT;
                    S_HALT:
                        state_reg <= S_IDLE;
                    default:
                        state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign req_floor = req_floor_reg;
    assign direction = direction_reg;
    assign valid_out = valid_reg;
    assign emergency = emergency_reg;
    assign pending   = pending_reg;

endmodule
